event_encoder: RTL and testbench
================================

# event_encoder

Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 decoder. Captures single-cycle event pulses on eight input lines into a pending register, then serialises them as 3-bit binary codes over a valid/ready output channel, one code per accepted transfer. Sits between raw event sources (interrupt lines, status strobes) and any consumer that expects a 3-bit index, such as the decoder driving a one-hot select.

## Interface
- `N_IN`, 8: number of event lines; fixed at 8 for this revision.
- `CODE_W`, 3: code width, equal to clog2(`N_IN`).

- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `IN` input 8: event pulses; bit k high for one cycle means one event on line k.
- `OUT` output 3: binary index of the granted line.
- `OUT_VALID` output 1: `OUT` holds a code.
- `OUT_READY` input 1: consumer accepts `OUT` this cycle.
- `PENDING` output 8: registered pending vector, for status only.
- `OVERFLOW` output 1: one-cycle pulse, meaning an event merged into an already-pending bit.

## Operation
- Pending register P is 8 bits.
  - Each cycle: P_next = (P & ~G) | IN.
  - G is the one-hot grant loaded into the output stage this cycle, or 0.
- A load occurs when (`OUT_VALID`==0 or `OUT_READY`==1) and P != 0.
  - The load selects the highest-index set bit of the registered P. `IN` arriving in the same cycle does not take part.
  - `OUT` is set to the index of that bit, `OUT_VALID` is set to 1, and that bit is cleared through G.
- Output stage FSM:
  - EMPTY (`OUT_VALID`=0):
    - Load → FULL.
    - Otherwise stay in EMPTY.
  - FULL (`OUT_VALID`=1):
    - `OUT_READY`=1 and load → FULL with the new code (back-to-back).
    - `OUT_READY`=1 and P==0 → EMPTY.
    - `OUT_READY`=0 → FULL. `OUT` and `OUT_VALID` are held stable.
- Handshake rules:
  - `OUT_VALID` never drops without `OUT_READY`.
  - `OUT` never changes while `OUT_VALID`=1 and `OUT_READY`=0.
- Overflow: `OVERFLOW` is 1 on the next cycle when both hold for any k:
  - `IN[k]`=1 and P[k]=1;
  - G[k]=0.
  - The event is merged and not counted. Events are level-merged, not queued.
- Same-bit re-arm: `IN[k]`=1 in the same cycle that G[k]=1. P[k] stays 1, this is a new event, and there is no overflow.
- An event on line k while code k sits in `OUT` is a new pending event. There is no overflow.
- `IN`=0 with bit 0 pending produces `OUT`=3'b000 with `OUT_VALID`=1. Code 0 is a real event and is distinguished only by `OUT_VALID`.

## Timing
- Reset values:
  - P=8'h00, `PENDING`=8'h00.
  - `OUT`=3'b000, `OUT_VALID`=0.
  - `OVERFLOW`=0.
  - FSM=EMPTY.
- Latency:
  - `IN` pulse at cycle t → P set at t+1 → `OUT_VALID` at t+2 when the output stage is free.
- Throughput: one code per cycle while `OUT_READY`=1 and P != 0.
- `PENDING` is the registered P, with no extra delay.
- `RST` mid-transfer:
  - Reset dominates all other inputs in that cycle.
  - The pending events and the code held in `OUT` are discarded.
  - `OUT_VALID`=0 on the following cycle.
  - `IN` sampled during the reset cycle is dropped.
- Outputs are combinationally independent of inputs. No path runs from `IN` or `OUT_READY` to `OUT` or `OUT_VALID` within a cycle.

## Structure
- Shared package `encoder_pkg`: constants `N_IN`=8 and `CODE_W`=3, plus the FSM state type {EMPTY, FULL}.
- One sub-module, `priority_pick`:
  - Combinational; input 8-bit vector.
  - Outputs: the 3-bit highest-set index, the one-hot grant, and an any-set flag.
- The top level holds P, the output register, the FSM and the overflow logic.

## Test plan
- Reset then idle: `RST`=1 for 2 cycles, `IN`=0 → `OUT_VALID`=0, `OUT`=0, `PENDING`=8'h00, `OVERFLOW`=0 on every cycle.
- Single event: `IN`=8'h20 for 1 cycle at t, `OUT_READY`=1 → `PENDING`=8'h20 at t+1; `OUT`=3'd5 and `OUT_VALID`=1 at t+2; `OUT_VALID`=0 at t+3.
- Priority drain: `IN`=8'h93 for 1 cycle, `OUT_READY`=1 → codes 7, 4, 1, 0 on consecutive cycles, then `OUT_VALID`=0.
- Backpressure: `IN`=8'h06, `OUT_READY`=0 for 5 cycles → `OUT`=3'd2 is held stable with `OUT_VALID`=1 and `PENDING`=8'h02. Raising `OUT_READY` then yields `OUT`=3'd1 on the next cycle.
- Overflow and re-arm:
  - Hold `OUT_READY`=0 with `OUT`=3 held, pulse `IN`=8'h01 twice → `OVERFLOW` pulses once after the second pulse; `PENDING`=8'h01.
  - Pulse `IN[0]` again in the cycle bit 0 is loaded → no `OVERFLOW`, and code 0 is emitted twice in total.
- Reset mid-drain: `IN`=8'hFF, then assert `RST` after 3 codes → `OUT_VALID`=0 and `PENDING`=8'h00 the next cycle, and no further codes appear.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants and output-stage state type for the event encoder.
package encoder_pkg;
   localparam int N_IN   = 8;
   localparam int CODE_W = 3;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;
endpackage

// File: rtl/priority_pick.sv
// Combinational highest-index picker: binary index, one-hot grant and any-set flag.
module priority_pick
   import encoder_pkg::*;
(
   input  logic [N_IN-1:0]   vec_i,
   output logic [CODE_W-1:0] idx_o,
   output logic [N_IN-1:0]   grant_o,
   output logic              any_o
);

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      idx_o   = '0;
      grant_o = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (vec_i[i]) begin
            idx_o   = CODE_W'(i);
            grant_o = N_IN'(1) << i;
         end
      end
   end

   assign any_o = |vec_i;

endmodule

// File: rtl/event_encoder.sv
// Captures event pulses into a pending register and serialises them as 3-bit
// codes, highest index first, over a valid/ready output channel.
module event_encoder
   import encoder_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_IN-1:0]   IN,
   output logic [CODE_W-1:0] OUT,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [N_IN-1:0]   PENDING,
   output logic              OVERFLOW
);

   // Handshake: a code transfers on a cycle where OUT_VALID and OUT_READY are
   // both high; while OUT_VALID=1 and OUT_READY=0, OUT and OUT_VALID hold.

   state_t              state_q, state_d;
   logic [N_IN-1:0]     pend_q, pend_d;
   logic [CODE_W-1:0]   out_q, out_d;
   logic                ovf_q, ovf_d;

   logic [CODE_W-1:0]   pick_idx;
   logic [N_IN-1:0]     pick_grant;
   logic                pick_any;
   logic                load;
   logic [N_IN-1:0]     grant;

   // Only the registered pending vector competes; same-cycle IN waits a cycle.
   priority_pick u_pick (
      .vec_i   (pend_q),
      .idx_o   (pick_idx),
      .grant_o (pick_grant),
      .any_o   (pick_any)
   );

   assign load  = ((state_q == EMPTY) || OUT_READY) && pick_any;
   assign grant = load ? pick_grant : '0;

   always_comb begin
      pend_d = (pend_q & ~grant) | IN;
      out_d  = load ? pick_idx : out_q;
      ovf_d  = |(IN & pend_q & ~grant);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= EMPTY;
         pend_q  <= '0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (load) state_d = FULL;
         FULL:  if (OUT_READY && !load) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      OUT_VALID = (state_q == FULL);
      OUT       = out_q;
      PENDING   = pend_q;
      OVERFLOW  = ovf_q;
   end

endmodule

// File: tb/tb_event_encoder.sv
// Directed bench for event_encoder: reset, drain order, backpressure,
// overflow/re-arm and reset during a drain.
module tb_event_encoder;
   import encoder_pkg::*;

   logic              CLK = 1'b0;
   logic              RST;
   logic [N_IN-1:0]   IN;
   logic [CODE_W-1:0] OUT;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic [N_IN-1:0]   PENDING;
   logic              OVERFLOW;

   int n_cmp = 0;
   int n_err = 0;

   event_encoder dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN        (IN),
      .OUT       (OUT),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .PENDING   (PENDING),
      .OVERFLOW  (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   // Advance one rising edge and settle; inputs change here, outputs are read here.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [2:0] code,
                          input logic [7:0] pend, input logic ovf);
      chk({tag, ".valid"}, {7'b0, OUT_VALID}, {7'b0, v});
      if (v) chk({tag, ".out"}, {5'b0, OUT}, {5'b0, code});
      chk({tag, ".pending"}, PENDING, pend);
      chk({tag, ".overflow"}, {7'b0, OVERFLOW}, {7'b0, ovf});
   endtask

   initial begin
      RST = 1'b1; IN = '0; OUT_READY = 1'b1;

      // Reset then idle
      step(); chk_out("rst0", 1'b0, 3'd0, 8'h00, 1'b0); chk("rst0.out", {5'b0, OUT}, 8'h00);
      step(); chk_out("rst1", 1'b0, 3'd0, 8'h00, 1'b0); chk("rst1.out", {5'b0, OUT}, 8'h00);
      RST = 1'b0;
      step(); chk_out("idle", 1'b0, 3'd0, 8'h00, 1'b0);

      // Single event
      IN = 8'h20;
      step(); IN = '0; chk_out("single.t1", 1'b0, 3'd0, 8'h20, 1'b0);
      step(); chk_out("single.t2", 1'b1, 3'd5, 8'h00, 1'b0);
      step(); chk_out("single.t3", 1'b0, 3'd0, 8'h00, 1'b0);

      // Priority drain
      IN = 8'h93;
      step(); IN = '0; chk_out("drain.p", 1'b0, 3'd0, 8'h93, 1'b0);
      step(); chk_out("drain.c7", 1'b1, 3'd7, 8'h13, 1'b0);
      step(); chk_out("drain.c4", 1'b1, 3'd4, 8'h03, 1'b0);
      step(); chk_out("drain.c1", 1'b1, 3'd1, 8'h01, 1'b0);
      step(); chk_out("drain.c0", 1'b1, 3'd0, 8'h00, 1'b0);
      step(); chk_out("drain.end", 1'b0, 3'd0, 8'h00, 1'b0);

      // Backpressure
      OUT_READY = 1'b0; IN = 8'h06;
      step(); IN = '0; chk_out("bp.p", 1'b0, 3'd0, 8'h06, 1'b0);
      step(); chk_out("bp.load", 1'b1, 3'd2, 8'h02, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(); chk_out("bp.hold", 1'b1, 3'd2, 8'h02, 1'b0);
      end
      OUT_READY = 1'b1;
      step(); chk_out("bp.c1", 1'b1, 3'd1, 8'h00, 1'b0);
      step(); chk_out("bp.end", 1'b0, 3'd0, 8'h00, 1'b0);

      // Overflow while code 3 is held, then same-bit re-arm on load
      OUT_READY = 1'b0; IN = 8'h08;
      step(); IN = '0; chk_out("ovf.p3", 1'b0, 3'd0, 8'h08, 1'b0);
      step(); chk_out("ovf.hold3", 1'b1, 3'd3, 8'h00, 1'b0);
      IN = 8'h08;
      step(); IN = '0; chk_out("ovf.same_code", 1'b1, 3'd3, 8'h08, 1'b0);
      RST = 1'b1;
      step(); RST = 1'b0; chk_out("ovf.clr", 1'b0, 3'd0, 8'h00, 1'b0);
      IN = 8'h08;
      step(); IN = '0; chk_out("ovf.p3b", 1'b0, 3'd0, 8'h08, 1'b0);
      step(); chk_out("ovf.hold3b", 1'b1, 3'd3, 8'h00, 1'b0);
      IN = 8'h01;
      step(); IN = '0; chk_out("ovf.pulse1", 1'b1, 3'd3, 8'h01, 1'b0);
      step(); chk_out("ovf.gap", 1'b1, 3'd3, 8'h01, 1'b0);
      IN = 8'h01;
      step(); IN = '0; chk_out("ovf.pulse2", 1'b1, 3'd3, 8'h01, 1'b1);
      step(); chk_out("ovf.one_shot", 1'b1, 3'd3, 8'h01, 1'b0);
      OUT_READY = 1'b1; IN = 8'h01;
      step(); IN = '0; chk_out("rearm.c0a", 1'b1, 3'd0, 8'h01, 1'b0);
      step(); chk_out("rearm.c0b", 1'b1, 3'd0, 8'h00, 1'b0);
      step(); chk_out("rearm.end", 1'b0, 3'd0, 8'h00, 1'b0);

      // Reset mid-drain; IN during reset is dropped
      IN = 8'hFF;
      step(); IN = '0; chk_out("rd.p", 1'b0, 3'd0, 8'hFF, 1'b0);
      step(); chk_out("rd.c7", 1'b1, 3'd7, 8'h7F, 1'b0);
      step(); chk_out("rd.c6", 1'b1, 3'd6, 8'h3F, 1'b0);
      step(); chk_out("rd.c5", 1'b1, 3'd5, 8'h1F, 1'b0);
      RST = 1'b1; IN = 8'hAA;
      step(); RST = 1'b0; IN = '0; chk_out("rd.rst", 1'b0, 3'd0, 8'h00, 1'b0);
      chk("rd.rst.out", {5'b0, OUT}, 8'h00);
      for (int i = 0; i < 3; i++) begin
         step(); chk_out("rd.quiet", 1'b0, 3'd0, 8'h00, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
